// File: rtl/pixel_pkg.sv
// Package: pixel_pkg
// Shared pixel type and lane-selection helper for the pixel serializer slice.
package pixel_pkg;

    localparam int PIX_CW    = 8;
    localparam int MAX_LANES = 32;

    typedef struct packed {
        logic [PIX_CW-1:0] r;
        logic [PIX_CW-1:0] g;
        logic [PIX_CW-1:0] b;
    } rgb_px_t;

    // Index of the next lane to emit: highest set bit when msb_first, else lowest.
    // Returns 0 for an empty mask; callers qualify with their own valid flag.
    function automatic int first_lane(input logic [MAX_LANES-1:0] mask,
                                      input int                   lanes,
                                      input logic                 msb_first);
        int idx;
        idx = 0;
        if (msb_first) begin
            for (int i = 0; i < MAX_LANES; i++) begin
                if (i < lanes && mask[i]) idx = i;
            end
        end else begin
            for (int i = MAX_LANES - 1; i >= 0; i--) begin
                if (i < lanes && mask[i]) idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pixel_ser_slot.sv
// Module: pixel_ser_slot
// One ping-pong buffer slot: holds a packed word, the mask of lanes still to be
// emitted and the end-of-line tag, and presents the next pixel in emission order.
module pixel_ser_slot
    import pixel_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [LANES*CW-1:0] load_r,
    input  logic [LANES*CW-1:0] load_g,
    input  logic [LANES*CW-1:0] load_b,
    input  logic [LANES-1:0]    load_keep,
    input  logic                load_last,
    input  logic                pop,
    output logic                loaded,
    output logic [CW-1:0]       px_r,
    output logic [CW-1:0]       px_g,
    output logic [CW-1:0]       px_b,
    output logic                px_last,
    output logic                px_final
);

    localparam int LW = $clog2(LANES);

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_LOADED
    } slot_state_t;

    slot_state_t         state;
    slot_state_t         state_next;
    logic [LANES*CW-1:0] data_r;
    logic [LANES*CW-1:0] data_g;
    logic [LANES*CW-1:0] data_b;
    logic [LANES-1:0]    mask;
    logic [LANES-1:0]    mask_after_pop;
    logic                last_flag;
    logic [LW-1:0]       lane;

    // Pick the lane to present and the mask that remains once it transfers
    always_comb begin
        lane           = LW'(first_lane(MAX_LANES'(mask), LANES, MSB_FIRST));
        mask_after_pop = mask & ~(LANES'(1) << lane);
    end

    assign px_r     = data_r[int'(lane)*CW +: CW];
    assign px_g     = data_g[int'(lane)*CW +: CW];
    assign px_b     = data_b[int'(lane)*CW +: CW];
    assign px_final = (mask_after_pop == '0);
    assign px_last  = last_flag & px_final;
    assign loaded   = (state == SLOT_LOADED);

    // Slot occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SLOT_EMPTY;
        else        state <= state_next;
    end

    // Slot fills on a kept word and empties when its final kept lane transfers
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY:  if (load)             state_next = SLOT_LOADED;
            SLOT_LOADED: if (pop && px_final)  state_next = SLOT_EMPTY;
            default:                           state_next = SLOT_EMPTY;
        endcase
    end

    // Word capture on load; retire the presented lane on each output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= '0;
            data_g    <= '0;
            data_b    <= '0;
            mask      <= '0;
            last_flag <= 1'b0;
        end else if (load) begin
            data_r    <= load_r;
            data_g    <= load_g;
            data_b    <= load_b;
            mask      <= load_keep;
            last_flag <= load_last;
        end else if (pop) begin
            mask      <= mask_after_pop;
        end
    end

endmodule

// File: rtl/pixel_serializer.sv
// Module: pixel_serializer
// Turns packed LANES-pixel RGB words into one pixel per cycle through a
// two-slot ping-pong buffer with valid/ready on both sides.
// Optional feature macro: PIXEL_SER_STATS_EN enables the pix_count transfer counter.
module pixel_serializer
    import pixel_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*CW-1:0] in_r,
    input  logic [LANES*CW-1:0] in_g,
    input  logic [LANES*CW-1:0] in_b,
    input  logic [LANES-1:0]    in_keep,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_r,
    output logic [CW-1:0]       out_g,
    output logic [CW-1:0]       out_b,
    output logic                out_last,
    output logic [31:0]         pix_count
);

    typedef enum logic {
        OUT_IDLE,
        OUT_PRESENT
    } out_state_t;

    out_state_t    out_state;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          keep_any;
    logic          accept;
    logic          out_fire;
    logic [1:0]    slot_load;
    logic [1:0]    slot_pop;
    logic [1:0]    slot_loaded;
    logic [1:0]    slot_last;
    logic [1:0]    slot_final;
    logic [CW-1:0] slot_r [2];
    logic [CW-1:0] slot_g [2];
    logic [CW-1:0] slot_b [2];

    // Ready depends only on registered slot state, never on out_ready
    assign in_ready = ~(slot_loaded[0] & slot_loaded[1]);
    assign keep_any = |in_keep;
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Route loads to the write slot and output transfers to the read slot;
    // zero-keep words are accepted but never occupy a slot
    always_comb begin
        slot_load         = '0;
        slot_pop          = '0;
        slot_load[wr_ptr] = accept & keep_any;
        slot_pop[rd_ptr]  = out_fire;
    end

    for (genvar s = 0; s < 2; s++) begin : g_slot
        pixel_ser_slot #(
            .LANES     (LANES),
            .CW        (CW),
            .MSB_FIRST (MSB_FIRST)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[s]),
            .load_r    (in_r),
            .load_g    (in_g),
            .load_b    (in_b),
            .load_keep (in_keep),
            .load_last (in_last),
            .pop       (slot_pop[s]),
            .loaded    (slot_loaded[s]),
            .px_r      (slot_r[s]),
            .px_g      (slot_g[s]),
            .px_b      (slot_b[s]),
            .px_last   (slot_last[s]),
            .px_final  (slot_final[s])
        );
    end

    // Output stage presents the head slot directly, so a word shows up the cycle
    // after it is accepted and stays put while the consumer stalls
    always_comb begin
        out_state = slot_loaded[rd_ptr] ? OUT_PRESENT : OUT_IDLE;
        out_valid = (out_state == OUT_PRESENT);
        out_r     = out_valid ? slot_r[rd_ptr] : '0;
        out_g     = out_valid ? slot_g[rd_ptr] : '0;
        out_b     = out_valid ? slot_b[rd_ptr] : '0;
        out_last  = out_valid & slot_last[rd_ptr];
    end

    // Ping-pong pointers: write advances per stored word, read per drained word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept && keep_any)              wr_ptr <= ~wr_ptr;
            if (out_fire && slot_final[rd_ptr])  rd_ptr <= ~rd_ptr;
        end
    end

`ifdef PIXEL_SER_STATS_EN
    logic [31:0] pix_count_q;

    // Free-running count of output transfers, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pix_count_q <= '0;
        else if (out_fire) pix_count_q <= pix_count_q + 32'd1;
    end

    assign pix_count = pix_count_q;
`else
    assign pix_count = 32'd0;
`endif

`ifndef SYNTHESIS
    zero_keep_last_dropped: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && in_ready && !keep_any && in_last))
        else $warning("pixel_serializer: in_last on a zero-keep word is dropped");
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// Testbench: tb_pixel_serializer
// Randomised scenarios against a queue-based reference of the expected pixel stream.
module tb_pixel_serializer;
    import pixel_pkg::*;

    localparam int LANES     = 4;
    localparam int CW        = 8;
    localparam bit MSB_FIRST = 1'b1;

    typedef struct {
        rgb_px_t px;
        logic    last;
        int      cyc;
    } pix_rec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*CW-1:0] in_r = '0;
    logic [LANES*CW-1:0] in_g = '0;
    logic [LANES*CW-1:0] in_b = '0;
    logic [LANES-1:0]    in_keep = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [CW-1:0]       out_r;
    logic [CW-1:0]       out_g;
    logic [CW-1:0]       out_b;
    logic                out_last;
    logic [31:0]         pix_count;

    pix_rec_t exp_q[$];
    pix_rec_t act_q[$];
    int       acc_cyc_q[$];
    int       kept[$];
    int       checks = 0;
    int       failures = 0;
    int       cyc = 0;
    int       exp_count = 0;

    pixel_serializer #(
        .LANES     (LANES),
        .CW        (CW),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .out_last  (out_last),
        .pix_count (pix_count)
    );

    // Free-running clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: expands accepted words into expected pixels (kept lanes in
    // emission order, last tag on the final one) and records observed output transfers
    always @(negedge clk) begin : monitor
        pix_rec_t rec;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                acc_cyc_q.push_back(cyc);
                kept.delete();
                for (int k = 0; k < LANES; k++) begin
                    int ln;
                    ln = MSB_FIRST ? (LANES - 1 - k) : k;
                    if (in_keep[ln]) kept.push_back(ln);
                end
                foreach (kept[j]) begin
                    rec.px.r = in_r[kept[j]*CW +: CW];
                    rec.px.g = in_g[kept[j]*CW +: CW];
                    rec.px.b = in_b[kept[j]*CW +: CW];
                    rec.last = in_last && (j == kept.size() - 1);
                    rec.cyc  = 0;
                    exp_q.push_back(rec);
                end
            end
            if (out_valid && out_ready) begin
                rec.px.r = out_r;
                rec.px.g = out_g;
                rec.px.b = out_b;
                rec.last = out_last;
                rec.cyc  = cyc;
                act_q.push_back(rec);
                exp_count++;
            end
        end
    end

    // Hard stop in case something wedges the whole run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_model();
        exp_q.delete();
        act_q.delete();
        acc_cyc_q.delete();
    endtask

    // Present one word and hold it until accepted; returns just after the accepting edge
    task automatic send_word(input logic [LANES*CW-1:0] r, input logic [LANES*CW-1:0] g,
                             input logic [LANES*CW-1:0] b, input logic [LANES-1:0] keep,
                             input logic last);
        int n;
        n = 0;
        in_r = r; in_g = g; in_b = b; in_keep = keep; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout in_ready got=%b want=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait until every expected pixel has come out and the output is idle
    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((out_valid || act_q.size() < exp_q.size()) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid || act_q.size() < exp_q.size()) begin
            failures++;
            $display("[TB] FAIL %s_drain got=%0d pixels want=%0d", tag, act_q.size(), exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if ({out_r, out_g, out_b} !== 24'h0) begin failures++; $display("[TB] FAIL reset_out_rgb got=%h want=000000", {out_r, out_g, out_b}); end
        checks++;
        if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got=%b want=0", out_last); end
        checks++;
        if (pix_count !== 32'd0) begin failures++; $display("[TB] FAIL reset_pix_count got=%0d want=0", pix_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_valid got=%b want=0", out_valid); end
        clear_model();
        exp_count = 0;
    endtask

    task automatic test_single_word();
        logic [CW-1:0] lit_r [4];
        int acc;
        lit_r = '{8'h10, 8'h20, 8'h30, 8'h40};
        out_ready = 1'b1;
        clear_model();
        send_word(32'h10203040, 32'h11213141, 32'h12223242, 4'hF, 1'b0);
        wait_drain("single");
        acc = (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -100;
        checks++;
        if (act_q.size() != 4) begin failures++; $display("[TB] FAIL single_count got=%0d want=4", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({act_q[i].px, act_q[i].last} !== {exp_q[i].px, exp_q[i].last}) begin
                failures++;
                $display("[TB] FAIL single_pixel[%0d] got=%h/%b want=%h/%b", i, act_q[i].px, act_q[i].last, exp_q[i].px, exp_q[i].last);
            end
            checks++;
            if (act_q[i].px.r !== lit_r[i]) begin failures++; $display("[TB] FAIL single_order[%0d] got=%h want=%h", i, act_q[i].px.r, lit_r[i]); end
            checks++;
            if (act_q[i].cyc != acc + 1 + i) begin failures++; $display("[TB] FAIL single_timing[%0d] got=%0d want=%0d", i, act_q[i].cyc, acc + 1 + i); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        clear_model();
        for (int w = 0; w < 3; w++) begin
            send_word($urandom, $urandom, $urandom, 4'hF, (w == 2));
        end
        wait_drain("b2b");
        checks++;
        if (act_q.size() != 12) begin failures++; $display("[TB] FAIL b2b_count got=%0d want=12", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({act_q[i].px, act_q[i].last} !== {exp_q[i].px, exp_q[i].last}) begin
                failures++;
                $display("[TB] FAIL b2b_pixel[%0d] got=%h/%b want=%h/%b", i, act_q[i].px, act_q[i].last, exp_q[i].px, exp_q[i].last);
            end
            checks++;
            if (act_q[i].cyc != act_q[0].cyc + i) begin failures++; $display("[TB] FAIL b2b_gap[%0d] got=%0d want=%0d", i, act_q[i].cyc, act_q[0].cyc + i); end
        end
    endtask

    task automatic test_stats();
        logic [31:0] want;
`ifdef PIXEL_SER_STATS_EN
        want = 32'd16;
`else
        want = 32'd0;
`endif
        checks++;
        if (pix_count !== want) begin failures++; $display("[TB] FAIL stats_pix_count got=%0d want=%0d", pix_count, want); end
    endtask

    task automatic test_keep_last();
        logic [LANES*CW-1:0] r;
        r = $urandom;
        out_ready = 1'b1;
        clear_model();
        send_word(r, $urandom, $urandom, 4'b0101, 1'b1);
        wait_drain("keep");
        checks++;
        if (act_q.size() != 2) begin failures++; $display("[TB] FAIL keep_count got=%0d want=2", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({act_q[i].px, act_q[i].last} !== {exp_q[i].px, exp_q[i].last}) begin
                failures++;
                $display("[TB] FAIL keep_pixel[%0d] got=%h/%b want=%h/%b", i, act_q[i].px, act_q[i].last, exp_q[i].px, exp_q[i].last);
            end
        end
        if (act_q.size() == 2) begin
            checks++;
            if (act_q[0].px.r !== r[2*CW +: CW] || act_q[0].last !== 1'b0) begin
                failures++; $display("[TB] FAIL keep_lane2 got=%h/%b want=%h/0", act_q[0].px.r, act_q[0].last, r[2*CW +: CW]);
            end
            checks++;
            if (act_q[1].px.r !== r[0 +: CW] || act_q[1].last !== 1'b1) begin
                failures++; $display("[TB] FAIL keep_lane0 got=%h/%b want=%h/1", act_q[1].px.r, act_q[1].last, r[0 +: CW]);
            end
        end
    endtask

    task automatic test_stall();
        bit               pat [12];
        bit               prev_stall;
        logic [3*CW+1:0]  held;
        pat = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1};
        out_ready = 1'b0;
        clear_model();
        send_word($urandom, $urandom, $urandom, 4'hF, 1'b0);
        send_word($urandom, $urandom, $urandom, 4'hF, 1'b1);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_full_in_ready got=%b want=0", in_ready); end
        prev_stall = out_valid && !out_ready;
        held = {out_valid, out_r, out_g, out_b, out_last};
        @(posedge clk); #1;
        foreach (pat[i]) begin
            out_ready = pat[i];
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ({out_valid, out_r, out_g, out_b, out_last} !== held) begin
                    failures++;
                    $display("[TB] FAIL stall_hold[%0d] got=%h want=%h", i, {out_valid, out_r, out_g, out_b, out_last}, held);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = {out_valid, out_r, out_g, out_b, out_last};
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain("stall");
        checks++;
        if (act_q.size() != 8) begin failures++; $display("[TB] FAIL stall_count got=%0d want=8", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({act_q[i].px, act_q[i].last} !== {exp_q[i].px, exp_q[i].last}) begin
                failures++;
                $display("[TB] FAIL stall_pixel[%0d] got=%h/%b want=%h/%b", i, act_q[i].px, act_q[i].last, exp_q[i].px, exp_q[i].last);
            end
        end
    endtask

    task automatic test_random();
        bit          done;
        logic [31:0] want;
        done = 1'b0;
        clear_model();
        fork
            begin
                for (int w = 0; w < 24; w++) begin
                    logic [LANES-1:0] keep;
                    logic             last;
                    keep = LANES'($urandom);
                    last = (keep != '0) ? 1'($urandom) : 1'b0;
                    send_word($urandom, $urandom, $urandom, keep, last);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("random");
        checks++;
        if (act_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL random_count got=%0d want=%0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({act_q[i].px, act_q[i].last} !== {exp_q[i].px, exp_q[i].last}) begin
                failures++;
                $display("[TB] FAIL random_pixel[%0d] got=%h/%b want=%h/%b", i, act_q[i].px, act_q[i].last, exp_q[i].px, exp_q[i].last);
            end
        end
`ifdef PIXEL_SER_STATS_EN
        want = 32'(exp_count);
`else
        want = 32'd0;
`endif
        checks++;
        if (pix_count !== want) begin failures++; $display("[TB] FAIL random_pix_count got=%0d want=%0d", pix_count, want); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        clear_model();
        send_word($urandom, $urandom, $urandom, 4'hF, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (act_q.size() != 2) begin failures++; $display("[TB] FAIL rstmid_before got=%0d want=2", act_q.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_out_valid got=%b want=0", out_valid); end
        checks++;
        if (pix_count !== 32'd0) begin failures++; $display("[TB] FAIL rstmid_pix_count got=%0d want=0", pix_count); end
        clear_model();
        exp_count = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_residual[%0d] got=%b want=0", i, out_valid); end
        end
        checks++;
        if (act_q.size() != 0) begin failures++; $display("[TB] FAIL rstmid_pixels got=%0d want=0", act_q.size()); end
        checks++;
        if (pix_count !== 32'd0) begin failures++; $display("[TB] FAIL rstmid_count_after got=%0d want=0", pix_count); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stats();
        test_keep_last();
        test_stall();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
